// File: rtl/sccb_init_sequencer.sv
// rtl/sccb_init_sequencer.sv - walks a register table and writes each entry to a camera over SCCB
module sccb_init_sequencer #(
   parameter logic [7:0] DEV_ADDR    = 8'h42,
   parameter int         NUM_ENTRIES = 76,
   parameter int         CLK_DIV     = 250,
   parameter int         DELAY_UNIT  = 50000,
   localparam int        TBL_AW      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [TBL_AW-1:0] tbl_addr,
   input  logic [15:0]       tbl_data,
   output logic              busy,
   output logic              done,
   output logic [7:0]        wr_count,
   output logic              sioc,
   inout  wire               siod
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int DLY_W = $clog2(255 * DELAY_UNIT + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [DLY_W-1:0]  DLY_UNIT  = DLY_W'(DELAY_UNIT);
   localparam logic [TBL_AW-1:0] ADDR_LAST = TBL_AW'(NUM_ENTRIES - 1);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_START  = 4'd3;
   localparam logic [3:0] S_SHIFT  = 4'd4;
   localparam logic [3:0] S_STOP   = 4'd5;
   localparam logic [3:0] S_GAP    = 4'd6;
   localparam logic [3:0] S_DELAY  = 4'd7;
   localparam logic [3:0] S_DONE   = 4'd8;

   logic [3:0]        state_q, state_d;
   logic [TBL_AW-1:0] tbl_addr_q, tbl_addr_d;
   logic [15:0]       entry_q, entry_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [7:0]        wr_count_q, wr_count_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              half_q, half_d;
   logic [1:0]        phase_q, phase_d;
   logic [3:0]        pos_q, pos_d;
   logic [DLY_W-1:0]  dly_q, dly_d;
   logic              sioc_q, sioc_d;
   logic              siod_oe_q, siod_oe_d;
   logic              siod_out_q, siod_out_d;

   logic              div_tick;
   logic              adv;
   logic [7:0]        cur_byte;

   assign tbl_addr = tbl_addr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign wr_count = wr_count_q;
   assign sioc     = sioc_q;
   assign siod     = siod_oe_q ? siod_out_q : 1'bz;

   // Sequencer next state plus the bus levels for the next cycle, so the pins come straight from flops
   always_comb begin
      state_d    = state_q;
      tbl_addr_d = tbl_addr_q;
      entry_d    = entry_q;
      busy_d     = busy_q;
      done_d     = done_q;
      wr_count_d = wr_count_q;
      div_d      = '0;
      half_d     = half_q;
      phase_d    = phase_q;
      pos_d      = pos_q;
      dly_d      = dly_q;
      adv        = 1'b0;
      div_tick   = (div_q == DIV_LAST);

      // The SIOC divider only runs in the bus-timed states and restarts at zero elsewhere
      if (state_q == S_START || state_q == S_SHIFT || state_q == S_STOP || state_q == S_GAP) begin
         div_d = div_tick ? '0 : div_q + DIV_W'(1);
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               tbl_addr_d = '0;
               wr_count_d = '0;
               done_d     = 1'b0;
               busy_d     = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            entry_d = tbl_data;
            if (tbl_data == 16'hFFFF) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (tbl_data[15:8] == 8'hF0) begin
               if (tbl_data[7:0] == 8'd0) begin
                  adv = 1'b1;
               end else begin
                  // Counts down to zero inclusive, hence the minus one
                  dly_d   = DLY_W'(tbl_data[7:0]) * DLY_UNIT - DLY_W'(1);
                  state_d = S_DELAY;
               end
            end else begin
               state_d = S_START;
               half_d  = 1'b0;
            end
         end
         S_START: begin
            if (div_tick) begin
               if (!half_q) begin
                  half_d = 1'b1;
               end else begin
                  state_d = S_SHIFT;
                  half_d  = 1'b0;
                  phase_d = 2'd0;
                  pos_d   = 4'd0;
               end
            end
         end
         S_SHIFT: begin
            if (div_tick) begin
               if (!half_q) begin
                  half_d = 1'b1;
               end else begin
                  half_d = 1'b0;
                  if (pos_q == 4'd8) begin
                     pos_d = 4'd0;
                     if (phase_q == 2'd2) begin
                        state_d = S_STOP;
                     end else begin
                        phase_d = phase_q + 2'd1;
                     end
                  end else begin
                     pos_d = pos_q + 4'd1;
                  end
               end
            end
         end
         S_STOP: begin
            if (div_tick) begin
               state_d = S_GAP;
               half_d  = 1'b0;
               if (wr_count_q != 8'hFF) begin
                  wr_count_d = wr_count_q + 8'd1;
               end
            end
         end
         S_GAP: begin
            if (div_tick) begin
               if (!half_q) begin
                  half_d = 1'b1;
               end else begin
                  adv = 1'b1;
               end
            end
         end
         S_DELAY: begin
            if (dly_q == '0) begin
               adv = 1'b1;
            end else begin
               dly_d = dly_q - DLY_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (adv) begin
         if (tbl_addr_q == ADDR_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end else begin
            tbl_addr_d = tbl_addr_q + TBL_AW'(1);
            state_d    = S_FETCH;
         end
      end

      case (phase_d)
         2'd1:    cur_byte = entry_d[15:8];
         2'd2:    cur_byte = entry_d[7:0];
         default: cur_byte = DEV_ADDR;
      endcase

      sioc_d     = 1'b1;
      siod_oe_d  = 1'b0;
      siod_out_d = 1'b0;
      case (state_d)
         S_START: begin
            sioc_d    = !half_d;
            siod_oe_d = 1'b1;
         end
         S_SHIFT: begin
            // Position 8 of each phase is the don't-care bit: line released
            sioc_d     = half_d;
            siod_oe_d  = (pos_d != 4'd8);
            siod_out_d = cur_byte[3'd7 - pos_d[2:0]];
         end
         S_STOP: siod_oe_d = 1'b1;
         default: ;
      endcase
   end

   // State registers with synchronous reset that overrides everything, including start
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         tbl_addr_q <= '0;
         entry_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_count_q <= '0;
         div_q      <= '0;
         half_q     <= 1'b0;
         phase_q    <= 2'd0;
         pos_q      <= 4'd0;
         dly_q      <= '0;
         sioc_q     <= 1'b1;
         siod_oe_q  <= 1'b0;
         siod_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tbl_addr_q <= tbl_addr_d;
         entry_q    <= entry_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wr_count_q <= wr_count_d;
         div_q      <= div_d;
         half_q     <= half_d;
         phase_q    <= phase_d;
         pos_q      <= pos_d;
         dly_q      <= dly_d;
         sioc_q     <= sioc_d;
         siod_oe_q  <= siod_oe_d;
         siod_out_q <= siod_out_d;
      end
   end

endmodule

// File: doc/sccb_init_sequencer.md
SCCB_INIT_SEQUENCER -- requirements
Module: sccb_init_sequencer

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 8'h42, 8-bit SCCB write ID sent in phase 1.
REQ-002 SHALL have parameter NUM_ENTRIES, default 76, table depth; TBL_AW = clog2(NUM_ENTRIES), minimum 1.
REQ-003 SHALL have parameter CLK_DIV, default 250, clk cycles per SIOC half-period; legal range 2 or more.
REQ-004 SHALL have parameter DELAY_UNIT, default 50000, clk cycles per delay-entry unit.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; every flop is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1 bit, one-cycle pulse that (re)runs the table.
REQ-008 SHALL have port tbl_addr, output, TBL_AW bits, entry index sent to the external synchronous ROM.
REQ-009 SHALL have port tbl_data, input, 16 bits, {reg[15:8], value[7:0]}, valid exactly 1 cycle after tbl_addr changes.
REQ-010 SHALL have port busy, output, 1 bit, high from the accepted start until done.
REQ-011 SHALL have port done, output, 1 bit, level signal, high after the table completes; cleared by start or reset.
REQ-012 SHALL have port wr_count, output, 8 bits, number of SCCB writes completed in the current run, saturating at 255.
REQ-013 SHALL have port sioc, output, 1 bit, SCCB clock.
REQ-014 SHALL have port siod, inout, 1 bit, SCCB data; driven 0/1 or released as Z.

Function
REQ-015 SHALL implement states IDLE, FETCH, DECODE, START, SHIFT, STOP, GAP, DELAY, DONE.
REQ-016 SHALL treat start as follows: accepted in IDLE or DONE; ignored in all other states.
REQ-017 On an accepted start, SHALL set tbl_addr=0, wr_count=0, done=0, busy=1 and go to FETCH.
REQ-018 FETCH SHALL last exactly 1 cycle; DECODE SHALL register tbl_data.
REQ-019 DECODE, entry 16'hFFFF: end marker; go to DONE with no bus activity.
REQ-020 DECODE, reg 8'hF0: delay entry; go to DELAY for value*DELAY_UNIT cycles; value 0 = 0 cycles, advance next cycle.
REQ-021 DECODE, any other entry: go to START and perform a 3-phase write: DEV_ADDR, reg, value.
REQ-022 START SHALL use CLK_DIV cycles of siod=0 with sioc=1, then CLK_DIV cycles of sioc=0.
REQ-023 SHIFT SHALL send 27 bits: 3 phases of 8 data bits MSB-first, each followed by 1 don't-care bit with siod=Z.
REQ-024 Each SHIFT bit SHALL be 2*CLK_DIV cycles: sioc low for the first CLK_DIV, high for the second; siod changes only when sioc falls.
REQ-025 STOP SHALL use CLK_DIV cycles of siod=0 with sioc=1, then siod released to Z.
REQ-026 On STOP completion, SHALL increment wr_count (saturating) and go to GAP.
REQ-027 GAP SHALL hold the bus idle (sioc=1, siod=Z) for 2*CLK_DIV cycles.
REQ-028 SHALL advance after GAP or DELAY: if tbl_addr == NUM_ENTRIES-1 go to DONE, else tbl_addr+1 and FETCH.
REQ-029 DONE SHALL set busy=0 and done=1, and hold the bus idle.
REQ-030 Outside START/SHIFT/STOP, SHALL keep sioc=1 and siod=Z.
REQ-031 siod SHALL never be driven 1 while any don't-care bit is active.
REQ-032 The SIOC divider and the delay counter SHALL be independent, and each SHALL be wide enough for its parameter.

Reset
REQ-033 On reset, SHALL take effect in the same cycle edge regardless of state, including mid-SHIFT.
REQ-034 After reset: state IDLE, tbl_addr=0, busy=0, done=0, wr_count=0, sioc=1, siod=Z.
REQ-035 A start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-036 CLK_DIV=4, NUM_ENTRIES=2, table {1280,1204}, start pulse -> two writes decoded by a bus monitor as 42/12/80 and 42/12/04; done rises with wr_count=2; busy is high for 2*(8+216+4+8)+2*3 cycles +/-2.
REQ-037 DELAY_UNIT=10, table {F003,1111}, start -> no bus activity for 30 cycles, then one write 42/11/11; wr_count=1.
REQ-038 Table {1111,FFFF,2222}, start -> exactly one write; done with tbl_addr=1, wr_count=1.
REQ-039 Reset asserted during bit 10 of SHIFT -> next cycle sioc=1, siod=Z, busy=0; a new start then replays from entry 0.
REQ-040 start pulses while busy -> ignored, run unaffected; start while done -> done drops next cycle and the table reruns.
REQ-041 All tests -> monitor checks siod is Z on every 9th bit and that siod is stable while sioc is high, except at start/stop.
